// File: rtl/fifo_stream_reader.sv
// ----------------------------------------------------------------------------
// fifo_stream_reader
//
// Read-side stage that sits after the FIFO address controller and its
// synchronous-read RAM. It issues pops into the controller, absorbs the RAM's
// one-cycle read latency, and presents the words as a valid/ready stream with
// a packet-boundary flag.
//
// A 3-entry output buffer gives full throughput. New pops are granted against
// a credit of (buffered + in flight) < 3. The credit never depends on m_ready,
// so there is no combinational path from the stream side back to the FIFO.
//
// Parameters
//   DATA_WIDTH        width of one FIFO word
//   PKT_LEN           words per packet (>= 1); m_last marks every PKT_LEN-th
//                     accepted word
//
// Ports
//   clk               rising-edge clock
//   reset             asynchronous, active-high; clears all state
//   enable            permits new pops; in-flight and buffered words still drain
//   fifo_empty        FIFO controller empty flag
//   fifo_read_enable  pop request to the FIFO controller (each one is a real pop)
//   fifo_rdata        RAM read data, valid the cycle after a pop
//   m_valid           output word valid
//   m_ready           downstream accept
//   m_data            output word (head of the buffer)
//   m_last            last word of the current packet
//   busy              a pop is in flight or the buffer holds data
// ----------------------------------------------------------------------------
module fifo_stream_reader #(
   parameter int DATA_WIDTH = 16,
   parameter int PKT_LEN    = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  fifo_empty,
   output logic                  fifo_read_enable,
   input  logic [DATA_WIDTH-1:0] fifo_rdata,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   output logic                  busy
);

   localparam int               CNT_W    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PKT_LEN - 1);

   logic [DATA_WIDTH-1:0] ob_mem [3];
   logic [1:0]            head;
   logic [1:0]            tail;
   logic [1:0]            occ;
   logic                  inflight;
   logic [CNT_W-1:0]      pkt_cnt;
   logic [2:0]            credit_used;
   logic                  xfer;

   // Circular pointer over three entries.
   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
      return (c == LAST_CNT) ? '0 : c + CNT_W'(1);
   endfunction

   // Pop grant: the in-flight word already owns a buffer slot, so counting
   // it here is what makes buffer overflow impossible.
   assign credit_used      = {1'b0, occ} + {2'b00, inflight};
   assign fifo_read_enable = enable & ~fifo_empty & (credit_used < 3'd3) & ~reset;

   assign m_valid = (occ != 2'd0);
   assign m_data  = ob_mem[head];
   assign m_last  = m_valid & (pkt_cnt == LAST_CNT);
   assign busy    = inflight | m_valid;
   assign xfer    = m_valid & m_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inflight <= 1'b0;
         occ      <= 2'd0;
         head     <= 2'd0;
         tail     <= 2'd0;
         pkt_cnt  <= '0;
         for (int i = 0; i < 3; i++) begin
            ob_mem[i] <= '0;
         end
      end else begin
         // Pop issued this cycle: RAM data appears next cycle.
         inflight <= fifo_read_enable;

         // RAM data for last cycle's pop lands at the tail.
         if (inflight) begin
            ob_mem[tail] <= fifo_rdata;
            tail         <= ptr_inc(tail);
         end

         // Stream transfer retires the head entry.
         if (xfer) begin
            head    <= ptr_inc(head);
            pkt_cnt <= cnt_inc(pkt_cnt);
         end

         // Arrival and transfer in the same cycle leave occupancy unchanged.
         case ({inflight, xfer})
            2'b10:   occ <= occ + 2'd1;
            2'b01:   occ <= occ - 2'd1;
            default: occ <= occ;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// ----------------------------------------------------------------------------
// tb_fifo_stream_reader
//
// Scoreboard bench for fifo_stream_reader. A behavioural FIFO (queue plus a
// one-cycle registered read port) feeds the DUT; expected words and m_last
// flags are pushed when words are loaded, and a monitor pops and compares on
// every accepted transfer. A second instance with PKT_LEN = 1 is exercised
// with a randomly toggling empty flag.
// ----------------------------------------------------------------------------
module tb_fifo_stream_reader;

   localparam int DW  = 16;
   localparam int PKT = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          enable, fifo_empty, fifo_read_enable;
   logic [DW-1:0] fifo_rdata;
   logic          m_valid, m_ready, m_last, busy;
   logic [DW-1:0] m_data;

   logic          en1, empty1, rd1;
   logic [DW-1:0] rdata1;
   logic          valid1, ready1, last1, busy1;
   logic [DW-1:0] data1;

   always #5 clk = ~clk;

   fifo_stream_reader #(.DATA_WIDTH(DW), .PKT_LEN(PKT)) dut (
      .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
      .fifo_read_enable(fifo_read_enable), .fifo_rdata(fifo_rdata),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .m_last(m_last), .busy(busy)
   );

   fifo_stream_reader #(.DATA_WIDTH(DW), .PKT_LEN(1)) dut1 (
      .clk(clk), .reset(reset), .enable(en1), .fifo_empty(empty1),
      .fifo_read_enable(rd1), .fifo_rdata(rdata1),
      .m_valid(valid1), .m_ready(ready1), .m_data(data1),
      .m_last(last1), .busy(busy1)
   );

   typedef struct packed {
      logic [DW-1:0] d;
      logic          l;
   } exp_t;

   int            n_pass = 0;
   int            n_total = 0;
   int            cyc = 0;
   int            pops = 0;
   int            xfers = 0;
   int            xfers1 = 0;
   int            exp_idx = 0;
   int            first_pop = -1, first_valid = -1, first_xfer = -1, last_xfer = -1;
   int            test_xfers = 0;
   bit            chk_occ = 1'b0;
   logic          force1 = 1'b0;
   logic          pop_s, pop_s1, prev_stall;
   logic [DW-1:0] prev_data;
   logic          prev_last;
   exp_t          mon_e;
   logic [DW-1:0] mon_d1;

   logic [DW-1:0] fifo_q  [$];
   logic [DW-1:0] fifo_q1 [$];
   exp_t          exp_q   [$];
   logic [DW-1:0] exp1_q  [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic refresh();
      fifo_empty = (fifo_q.size() == 0);
      empty1     = (fifo_q1.size() == 0) | force1;
   endtask

   task automatic load(input logic [DW-1:0] w, input bit expect_it);
      exp_t e;
      fifo_q.push_back(w);
      if (expect_it) begin
         e.d = w;
         e.l = ((exp_idx % PKT) == PKT - 1);
         exp_q.push_back(e);
         exp_idx++;
      end
      refresh();
   endtask

   task automatic mark();
      first_pop   = -1;
      first_valid = -1;
      first_xfer  = -1;
      last_xfer   = -1;
      test_xfers  = 0;
   endtask

   task automatic drain(input int max, input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < max) begin
         tick();
         n++;
      end
      chk(name, exp_q.size(), 0);
   endtask

   always @(posedge clk) cyc++;

   // Behavioural FIFO for the main instance: pop seen in cycle N -> data in N+1.
   always begin
      @(negedge clk);
      pop_s = fifo_read_enable;
      if (pop_s) begin
         pops++;
         if (first_pop < 0) first_pop = cyc;
         chk("pop_while_empty", fifo_empty, 0);
      end
      @(posedge clk);
      #1;
      if (pop_s && fifo_q.size() > 0) fifo_rdata = fifo_q.pop_front();
      refresh();
      if (chk_occ) chk("occ_le_3", ((pops - xfers) <= 3), 1);
   end

   // Monitor / scoreboard for the main instance.
   always @(negedge clk) begin
      if (prev_stall && !reset) begin
         chk("hold_valid", m_valid, 1);
         chk("hold_data", m_data, prev_data);
         chk("hold_last", m_last, prev_last);
      end
      if (m_valid && first_valid < 0) first_valid = cyc;
      if (m_valid && m_ready) begin
         xfers++;
         test_xfers++;
         if (first_xfer < 0) first_xfer = cyc;
         last_xfer = cyc;
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_xfer: got data %0h, expected no transfer", m_data);
         end else begin
            mon_e = exp_q.pop_front();
            chk("data", m_data, mon_e.d);
            chk("last", m_last, mon_e.l);
         end
      end
      prev_stall = m_valid & ~m_ready & ~reset;
      prev_data  = m_data;
      prev_last  = m_last;
   end

   // Behavioural FIFO for the PKT_LEN = 1 instance.
   always begin
      @(negedge clk);
      pop_s1 = rd1;
      if (pop_s1) chk("t6_pop_while_empty", empty1, 0);
      @(posedge clk);
      #1;
      if (pop_s1 && fifo_q1.size() > 0) rdata1 = fifo_q1.pop_front();
      refresh();
   end

   // Monitor for the PKT_LEN = 1 instance.
   always @(negedge clk) begin
      if (en1) chk("t6_last_eq_valid", last1, valid1);
      if (valid1 && ready1) begin
         xfers1++;
         chk("t6_last_on_xfer", last1, 1);
         if (exp1_q.size() == 0) begin
            n_total++;
            $display("FAIL t6_unexpected_xfer: got data %0h, expected no transfer", data1);
         end else begin
            mon_d1 = exp1_q.pop_front();
            chk("t6_data", data1, mon_d1);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int p0;
      reset      = 1'b1;
      enable     = 1'b0;
      m_ready    = 1'b0;
      fifo_rdata = '0;
      en1        = 1'b0;
      ready1     = 1'b0;
      rdata1     = '0;
      prev_stall = 1'b0;
      refresh();

      // Reset values
      #12;
      chk("rst_rd_en", fifo_read_enable, 0);
      chk("rst_valid", m_valid, 0);
      chk("rst_data", m_data, 0);
      chk("rst_last", m_last, 0);
      chk("rst_busy", busy, 0);
      tick();
      reset = 1'b0;
      tick();

      // Test 1: full-throughput stream, latency, packet boundaries
      mark();
      m_ready = 1'b1;
      for (int i = 1; i <= 16; i++) load(DW'(i), 1'b1);
      enable = 1'b1;
      drain(100, "t1_drain");
      chk("t1_latency", first_valid - first_pop, 2);
      chk("t1_xfers", test_xfers, 16);
      chk("t1_consecutive", last_xfer - first_xfer, 15);

      // Test 2: ten-cycle stall, exactly three pops, head held
      mark();
      enable  = 1'b0;
      m_ready = 1'b0;
      for (int i = 1; i <= 16; i++) load(DW'(i), 1'b1);
      p0     = pops;
      enable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (m_valid) chk("t2_hold_first", m_data, 16'h0001);
      end
      chk("t2_valid", m_valid, 1);
      chk("t2_pops", pops - p0, 3);
      m_ready = 1'b1;
      drain(100, "t2_drain");
      chk("t2_fifo_emptied", fifo_q.size(), 0);

      // Test 3: alternating ready with 20 words
      mark();
      chk_occ = 1'b1;
      for (int i = 0; i < 20; i++) load(DW'(16'h0100 + i), 1'b1);
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         m_ready = ~m_ready;
         tick();
         n++;
      end
      chk("t3_drain", exp_q.size(), 0);
      chk("t3_xfers", test_xfers, 20);
      chk_occ = 1'b0;

      // Test 4: enable dropped one cycle after a pop
      enable  = 1'b0;
      m_ready = 1'b1;
      tick();
      load(16'h0A00, 1'b1);
      load(16'h0A01, 1'b0);
      load(16'h0A02, 1'b0);
      load(16'h0A03, 1'b0);
      p0     = pops;
      enable = 1'b1;
      tick();
      enable = 1'b0;
      chk("t4_busy_inflight", busy, 1);
      tick();
      chk("t4_valid", m_valid, 1);
      chk("t4_data", m_data, 16'h0A00);
      tick();
      chk("t4_busy_done", busy, 0);
      repeat (3) tick();
      chk("t4_pops", pops - p0, 1);
      chk("t4_delivered", exp_q.size(), 0);
      fifo_q.delete();
      refresh();

      // Test 5: reset with two buffered words and one in flight
      load(16'h0C01, 1'b1);
      load(16'h0C02, 1'b1);
      enable = 1'b1;
      drain(50, "t5_pre_drain");
      m_ready = 1'b0;
      for (int i = 1; i <= 5; i++) load(DW'(16'h0D00 + i), 1'b0);
      p0 = pops;
      n  = 0;
      while ((pops - p0) < 3 && n < 20) begin
         tick();
         n++;
      end
      chk("t5_pops", pops - p0, 3);
      chk("t5_busy_pre", busy, 1);
      chk("t5_valid_pre", m_valid, 1);
      #2;
      reset = 1'b1;
      #1;
      chk("t5_rst_rd_en", fifo_read_enable, 0);
      chk("t5_rst_valid", m_valid, 0);
      chk("t5_rst_data", m_data, 0);
      chk("t5_rst_last", m_last, 0);
      chk("t5_rst_busy", busy, 0);
      fifo_q.delete();
      exp_q.delete();
      exp_idx    = 0;
      xfers      = pops;
      fifo_rdata = '0;
      refresh();
      tick();
      tick();
      reset   = 1'b0;
      m_ready = 1'b1;
      for (int i = 0; i < 8; i++) load(DW'(16'h0E00 + i), 1'b1);
      drain(60, "t5_post_drain");
      enable = 1'b0;

      // Test 6: PKT_LEN = 1 with a randomly toggling empty flag
      for (int i = 0; i < 24; i++) begin
         fifo_q1.push_back(DW'(16'h2000 + i));
         exp1_q.push_back(DW'(16'h2000 + i));
      end
      en1 = 1'b1;
      n   = 0;
      while (exp1_q.size() != 0 && n < 400) begin
         force1 = 1'($urandom_range(0, 1));
         ready1 = 1'($urandom_range(0, 1));
         refresh();
         tick();
         n++;
      end
      chk("t6_drain", exp1_q.size(), 0);
      chk("t6_xfers", xfers1, 24);
      en1    = 1'b0;
      force1 = 1'b0;
      refresh();
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
